// File: rtl/imem_loader.sv
// Program loader: assembles a byte stream into little-endian words and writes them to imem.
// Optional checksum byte and err flag are enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned Bpw   = DWIDTH / 8;
  localparam int unsigned BW    = (Bpw > 1) ? $clog2(Bpw) : 1;
  localparam int unsigned CW    = AWIDTH + 1;
  localparam int unsigned Depth = 1 << AWIDTH;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCount = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] StCheck = 3'd4;
`else
  // Drain cycle holding the final write strobe so done rises one cycle after it.
  localparam logic [2:0] StLast  = 3'd5;
`endif

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     widx_q, widx_d;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [DWIDTH-1:0] word_q, word_d;
  logic              wr_en_d;
  logic [AWIDTH-1:0] wr_addr_d;
  logic [DWIDTH-1:0] wr_data_d;
  logic              ready_d, busy_d;
  logic              ready_q, busy_q, done_q;
  logic              xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
`endif

  assign xfer = rx_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    err_d     = err_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCount;
          widx_d  = '0;
          bidx_d  = '0;
          word_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StCount: begin
        if (xfer) begin
          // Zero, or anything beyond the memory depth, loads the whole memory.
          if (rx_data == 8'd0 || {24'd0, rx_data} >= Depth) begin
            cnt_d = CW'(Depth);
          end else begin
            cnt_d = CW'(rx_data);
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = rx_data;
`endif
          state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          word_d[{bidx_q, 3'b000} +: 8] = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bidx_q == BW'(Bpw - 1)) begin
            wr_en_d   = 1'b1;
            wr_data_d = word_d;
            wr_addr_d = widx_q[AWIDTH-1:0];
            widx_d    = widx_q + 1'b1;
            bidx_d    = '0;
            if (widx_d == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StLast;
`endif
            end
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (xfer) begin
          err_d   = (rx_data != csum_q);
          state_d = StDone;
        end
      end
`else
      StLast: state_d = StDone;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d = (state_d == StCount) || (state_d == StData);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == StCheck);
    busy_d  = ready_d;
`else
    busy_d  = ready_d || (state_d == StLast);
`endif
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= (state_d == StDone);
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rx_ready = ready_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
